// File: rtl/mac_result_collector.sv
// mac_result_collector
//
// Serialises the N-lane result vector of the parallel MAC array into a
// single-port result memory, one M_WIDTH word per cycle. Complete result
// sets are captured into a small FIFO of whole sets (DEPTH_SETS entries).
// The head entry is drained lane 0 .. lane N-1 with no gaps. The array is
// never stalled. A set that finds the FIFO full is dropped and flagged.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle pulse that arms (or restarts) a run
//   base_addr       first write address, sampled on start
//   num_sets        result sets expected this run, sampled on start
//   C, valid        MAC array results (lane i = C[M_WIDTH*i +: M_WIDTH])
//   C_wr, C_addr,   registered result-memory write port
//   C_din
//   busy            high while the FSM is ACTIVE
//   done            one-cycle pulse after the last write of a run
//   overflow        sticky: a set was dropped because the FIFO was full
//   lane_err        sticky: valid was nonzero but not all-ones
//   C_set           (COLLECTOR_TAG_EN only) sequence index of the set
//                   being written, counting dropped sets
//
// Handshake: there is no backpressure. A set is offered by driving valid
// all-ones for one cycle. The memory side takes every cycle in which C_wr
// is high.
//
// Optional feature macro: COLLECTOR_TAG_EN (adds the C_set output).
module mac_result_collector #(
  parameter int N          = 6,
  parameter int WIDTH      = 16,
  parameter int M_WIDTH    = 2*WIDTH+N-1,
  parameter int ADDR_W     = 8,
  parameter int DEPTH_SETS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    num_sets,
  input  logic [N*M_WIDTH-1:0] C,
  input  logic [N-1:0]         valid,
  output logic                 C_wr,
  output logic [ADDR_W-1:0]    C_addr,
  output logic [M_WIDTH-1:0]   C_din,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic                 lane_err
`ifdef COLLECTOR_TAG_EN
  ,
  output logic [ADDR_W-1:0]    C_set
`endif
);

  localparam int PW = (DEPTH_SETS > 1) ? $clog2(DEPTH_SETS) : 1;
  localparam int CW = $clog2(DEPTH_SETS + 1);
  localparam int LW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   base_q, num_q, sets_seen_q, written_q;
  logic [LW-1:0]       lane_q;
  logic [PW-1:0]       wr_q, rd_q;
  logic [CW-1:0]       count_q;
  logic                c_wr_q, done_q, overflow_q, lane_err_q;
  logic [ADDR_W-1:0]   c_addr_q;
  logic [M_WIDTH-1:0]  c_din_q;

  // Set storage: data only, no reset needed (occupancy lives in count_q).
  logic [N*M_WIDTH-1:0] buf_q [DEPTH_SETS];

  logic                in_capture, cap_set, bad_set, draining, pop, push;
  logic [CW-1:0]       count_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [N*M_WIDTH-1:0] head;
  logic [M_WIDTH-1:0]  head_lane;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH_SETS - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    // start has priority over a same-cycle valid.
    in_capture = (state_q == ACTIVE) && !start && (sets_seen_q < num_q);
    cap_set    = in_capture && (&valid);
    bad_set    = in_capture && (|valid) && !(&valid);
    draining   = (state_q == ACTIVE) && (count_q != '0);
    // The head slot frees on the edge its last lane is written, so a
    // capture on that edge still finds room.
    pop        = draining && (lane_q == LW'(N - 1));
    push       = cap_set && ((count_q != CW'(DEPTH_SETS)) || pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    addr_d     = base_q + ADDR_W'(32'(written_q) * N) + ADDR_W'(lane_q);
    head       = buf_q[rd_q];
    head_lane  = head[int'(lane_q)*M_WIDTH +: M_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (push) buf_q[wr_q] <= C;
  end

`ifdef COLLECTOR_TAG_EN
  logic [ADDR_W-1:0] tag_q [DEPTH_SETS];
  logic [ADDR_W-1:0] c_set_q;

  always_ff @(posedge clk) begin
    if (push) tag_q[wr_q] <= sets_seen_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) c_set_q <= '0;
    else if (!start && draining) c_set_q <= tag_q[rd_q];
  end

  assign C_set = c_set_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      num_q       <= '0;
      sets_seen_q <= '0;
      written_q   <= '0;
      lane_q      <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      c_wr_q      <= 1'b0;
      c_addr_q    <= '0;
      c_din_q     <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      lane_err_q  <= 1'b0;
    end else begin
      c_wr_q <= 1'b0;
      done_q <= 1'b0;
      if (start) begin
        // Arm or restart: any drain in progress is abandoned.
        state_q     <= (num_sets == '0) ? IDLE : ACTIVE;
        done_q      <= (num_sets == '0);
        base_q      <= base_addr;
        num_q       <= num_sets;
        sets_seen_q <= '0;
        written_q   <= '0;
        lane_q      <= '0;
        wr_q        <= '0;
        rd_q        <= '0;
        count_q     <= '0;
        overflow_q  <= 1'b0;
        lane_err_q  <= 1'b0;
      end else if (state_q == ACTIVE) begin
        if (draining) begin
          c_wr_q   <= 1'b1;
          c_addr_q <= addr_d;
          c_din_q  <= head_lane;
          if (pop) begin
            lane_q    <= '0;
            rd_q      <= next_ptr(rd_q);
            written_q <= written_q + ADDR_W'(1);
          end else begin
            lane_q <= lane_q + LW'(1);
          end
        end
        if (push) wr_q <= next_ptr(wr_q);
        count_q <= count_d;
        // Dropped sets still advance the sequence count.
        if (cap_set) sets_seen_q <= sets_seen_q + ADDR_W'(1);
        if (cap_set && !push) overflow_q <= 1'b1;
        if (bad_set) lane_err_q <= 1'b1;
        // Empty FIFO here means the final write issued on the previous edge.
        if ((count_q == '0) && (sets_seen_q == num_q)) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign C_wr     = c_wr_q;
  assign C_addr   = c_addr_q;
  assign C_din    = c_din_q;
  assign busy     = (state_q == ACTIVE);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign lane_err = lane_err_q;

endmodule

// File: tb/tb_mac_result_collector.sv
// Self-checking bench for mac_result_collector. The reference model works
// on whole sets and a timeline: each accepted set occupies the buffer from
// its capture edge until the edge of its last lane write, and its writes
// start at the later of (capture+1) and (previous set's end+1).
module tb_mac_result_collector;
  localparam int N     = 6;
  localparam int WIDTH = 16;
  localparam int MW    = 2*WIDTH+N-1;
  localparam int AW    = 8;
  localparam int DEPTH = 2;
  localparam int EW    = 16 + AW + MW + AW;

  logic          clk, rst, start;
  logic [AW-1:0] base_addr, num_sets;
  logic [N*MW-1:0] C;
  logic [N-1:0]  valid;
  logic          c_wr, busy, done, overflow, lane_err;
  logic [AW-1:0] c_addr, c_set;
  logic [MW-1:0] c_din;

  mac_result_collector #(.N(N), .WIDTH(WIDTH), .ADDR_W(AW), .DEPTH_SETS(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_sets(num_sets), .C(C), .valid(valid), .C_wr(c_wr), .C_addr(c_addr),
    .C_din(c_din), .busy(busy), .done(done), .overflow(overflow),
    .lane_err(lane_err)
`ifdef COLLECTOR_TAG_EN
    , .C_set(c_set)
`endif
  );

`ifndef COLLECTOR_TAG_EN
  assign c_set = '0;
`endif

  // ---------------- clock / reset / edge counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];   // {edge, addr, data, tag}
  int            done_q[$];  // edge numbers at which done is expected
  int checks = 0;
  int errors = 0;

  // ---------------- reference model state ----------------
  int m_base, m_num, m_seen, m_acc, m_last_end, m_done_edge;
  int occ_last[$];
  bit m_ovf, m_lerr, m_started;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_start(input int c0, input int base, input int num);
    exp_q.delete();
    done_q.delete();
    occ_last.delete();
    m_base = base; m_num = num; m_seen = 0; m_acc = 0; m_last_end = c0;
    m_ovf = 0; m_lerr = 0; m_started = 1; m_done_edge = -1;
    if (num == 0) begin
      m_done_edge = c0;
      done_q.push_back(c0);
    end
  endtask

  task automatic model_valid(input int c, input logic [N-1:0] v, input logic [N*MW-1:0] d);
    int occ, s;
    logic [AW-1:0] a;
    logic [MW-1:0] w;
    if (!m_started || m_seen >= m_num || v == '0) return;
    if (v != '1) begin
      m_lerr = 1;
      return;
    end
    occ = 0;
    foreach (occ_last[i]) if (occ_last[i] > c) occ++;
    if (occ < DEPTH) begin
      s = (c + 1 > m_last_end + 1) ? c + 1 : m_last_end + 1;
      for (int l = 0; l < N; l++) begin
        a = AW'(m_base + m_acc*N + l);
        w = d[l*MW +: MW];
`ifdef COLLECTOR_TAG_EN
        exp_q.push_back({16'(s + l), a, w, AW'(m_seen)});
`else
        exp_q.push_back({16'(s + l), a, w, AW'(0)});
`endif
      end
      m_last_end = s + N - 1;
      occ_last.push_back(m_last_end);
      m_acc++;
    end else begin
      m_ovf = 1;
    end
    m_seen++;
    if (m_seen == m_num) begin
      m_done_edge = m_last_end + 1;
      done_q.push_back(m_done_edge);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e, got;
    if (!rst) begin
      if (c_wr) begin
        checks++;
        got = {16'(cyc), c_addr, c_din, c_set};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got %0h expected none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL write got %0h expected %0h", got, e);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0][EW-1 -: 16] <= 16'(cyc)) begin
        checks++; errors++;
        e = exp_q.pop_front();
        $display("FAIL missing_write got none expected %0h", e);
      end
      if (done) begin
        checks++;
        if (done_q.size() == 0 || done_q[0] != cyc) begin
          errors++;
          $display("FAIL done_pulse got edge %0d expected %0d", cyc,
                   (done_q.size() != 0) ? done_q[0] : -1);
        end
        if (done_q.size() != 0) void'(done_q.pop_front());
      end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
        checks++; errors++;
        $display("FAIL missing_done got none expected edge %0d", done_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit st, input int base, input int num,
                       input logic [N-1:0] v, input logic [N*MW-1:0] d);
    @(negedge clk);
    #1;
    start = st; base_addr = AW'(base); num_sets = AW'(num); valid = v; C = d;
    if (st) model_start(cyc + 1, base, num);
    else if (!rst) model_valid(cyc + 1, v, d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, '0, '0);
  endtask

  function automatic logic [N*MW-1:0] rand_data();
    logic [N*MW-1:0] d;
    d = '0;
    for (int l = 0; l < N; l++) d[l*MW +: MW] = MW'({$urandom, $urandom});
    return d;
  endfunction

  function automatic logic [N*MW-1:0] seq_data();
    logic [N*MW-1:0] d;
    d = '0;
    for (int l = 0; l < N; l++) d[l*MW +: MW] = MW'(l + 1);
    return d;
  endfunction

  task automatic wait_drained(input string name);
    for (int i = 0; i < 400 && (exp_q.size() != 0 || done_q.size() != 0); i++) idle(1);
    check(name, 64'(exp_q.size() + done_q.size()), 64'(0));
  endtask

  task automatic check_flags(input string name);
    bit exp_busy;
    exp_busy = m_started && (m_done_edge < 0 || cyc < m_done_edge);
    check({name, "_busy"}, 64'(busy), 64'(exp_busy));
    check({name, "_overflow"}, 64'(overflow), 64'(m_ovf));
    check({name, "_lane_err"}, 64'(lane_err), 64'(m_lerr));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int num, base, found;
    logic [N-1:0] v;
    rst = 1'b1; start = 0; base_addr = '0; num_sets = '0; valid = '0; C = '0;
    m_started = 0; m_done_edge = -1; m_ovf = 0; m_lerr = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({c_wr, c_addr, c_din, busy, done, overflow, lane_err}), 64'(0));
    #1 rst = 1'b0;

    // 1: single set, lanes 1..6 at 0x10
    drive(1, 'h10, 1, '0, '0);
    drive(0, 0, 0, '1, seq_data());
    idle(2);
    check_flags("t1_mid");
    wait_drained("t1_drain");
    check_flags("t1_end");

    // 2: three sets spaced six cycles apart, gap-free stream
    drive(1, 'h20, 3, '0, '0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, '1, rand_data());
      idle(5);
    end
    wait_drained("t2_drain");
    check_flags("t2_end");

    // 3: four back-to-back sets, two dropped
    drive(1, 'h40, 4, '0, '0);
    for (int k = 0; k < 4; k++) drive(0, 0, 0, '1, rand_data());
    check_flags("t3_mid");
    wait_drained("t3_drain");
    check_flags("t3_end");

    // 4: partial valid flags lane_err, later full set captured
    drive(1, 'h60, 1, '0, '0);
    drive(0, 0, 0, 6'h0F, rand_data());
    idle(3);
    check_flags("t4_mid");
    drive(0, 0, 0, '1, rand_data());
    wait_drained("t4_drain");
    check_flags("t4_end");

    // 5: address wrap
    drive(1, 'hFC, 1, '0, '0);
    drive(0, 0, 0, '1, rand_data());
    wait_drained("t5_drain");

    // start with valid in the same cycle, then num_sets==0
    drive(1, 'h80, 1, '1, rand_data());
    idle(2);
    drive(0, 0, 0, '1, rand_data());
    wait_drained("start_prio_drain");
    drive(1, 'h90, 0, '0, '0);
    wait_drained("zero_sets");
    check_flags("zero_sets_end");

    // restart mid-drain
    drive(1, 'hA0, 3, '0, '0);
    drive(0, 0, 0, '1, rand_data());
    drive(0, 0, 0, '1, rand_data());
    idle(3);
    drive(1, 'hB0, 1, '0, '0);
    idle(1);
    check_flags("restart_mid");
    drive(0, 0, 0, '1, rand_data());
    wait_drained("restart_drain");

    // randomized runs
    for (int r = 0; r < 10; r++) begin
      num = $urandom_range(0, 5);
      base = $urandom_range(0, 255);
      drive(1, base, num, '0, '0);
      for (int t = 0; t < 60 && m_seen < m_num; t++) begin
        idle($urandom_range(0, 7));
        case ($urandom_range(0, 9))
          0: v = N'($urandom_range(1, 62));
          1: v = '0;
          default: v = '1;
        endcase
        drive(0, 0, 0, v, rand_data());
      end
      drive(0, 0, 0, '1, rand_data());  // extra set after the run is ignored
      wait_drained("rand_drain");
      check_flags("rand_end");
    end

    // 6: asynchronous reset during lane 3 of a drain
    drive(1, 'h30, 3, '0, '0);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, '1, rand_data());
    start = 0; valid = '0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (c_wr && c_addr == AW'('h30 + N + 3)) found = 1;
    end
    check("t6_lane3_seen", 64'(found), 64'(1));
    #2 rst = 1'b1;
    exp_q.delete(); done_q.delete(); m_started = 0; m_done_edge = -1;
    #1;
    check("t6_async_reset", 64'({c_wr, busy, overflow}), 64'(0));
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    m_ovf = 0; m_lerr = 0;
    drive(0, 0, 0, '1, rand_data());  // IDLE after reset: ignored
    idle(10);
    check_flags("t6_after");
    check("final_queues", 64'(exp_q.size() + done_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_result_collector.md
Name: mac_result_collector

Overview:
- Drains the N-lane result vector of the parallel MAC array (C / valid) into a single-port result memory, one M_WIDTH word per cycle.
- Sits directly downstream of the MAC array: the array produces N results in one cycle, and this block serialises them into C_wr/C_addr/C_din writes.
- A small set buffer absorbs bursts. Overflow and lane-misalignment are flagged and never stall the array.

Parameters:
- N, 6, number of MAC lanes per result set
- WIDTH, 16, MAC operand width
- M_WIDTH, 2*WIDTH+N-1, width of one MAC result
- ADDR_W, 8, result memory address width
- DEPTH_SETS, 2, buffer depth in whole N-lane sets (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; arms a new collection run
- base_addr  in  ADDR_W  first write address, sampled on start
- num_sets  in  ADDR_W  result sets expected this run, sampled on start
- C  in  N*M_WIDTH  MAC array results; lane i = C[M_WIDTH*(i+1)-1:M_WIDTH*i]
- valid  in  N  per-lane result valid from the MAC array
- C_wr  out  1  result memory write strobe
- C_addr  out  ADDR_W  result memory write address
- C_din  out  M_WIDTH  result memory write data
- busy  out  1  high while state is ACTIVE
- done  out  1  one-cycle pulse when the run completes
- overflow  out  1  sticky; a set arrived while the buffer was full
- lane_err  out  1  sticky; valid was nonzero but not all-ones

Behaviour:
Reset:
- Asynchronous reset forces all outputs to 0 and state to IDLE.
- Reset also empties the buffer and clears all counters.

States:
- IDLE: valid is ignored.
  - start -> ACTIVE. On the same edge: latch base_addr and num_sets, clear counters, overflow and lane_err.
  - start with num_sets==0 -> pulse done next cycle, stay IDLE, no writes.
- ACTIVE: capture and drain.
  - Exits to IDLE when sets_seen==num_sets, the buffer is empty and the last write has issued.
  - done pulses in the cycle after the last C_wr.

Capture (ACTIVE only, while sets_seen<num_sets):
- valid==all-ones: sets_seen++.
  - If the buffer is not full, the N lanes are stored as one entry.
  - If the buffer is full, the set is dropped and overflow is set.
  - Dropped sets still count toward num_sets.
- valid nonzero and not all-ones: no capture, lane_err set, sets_seen unchanged.
- valid arriving after sets_seen==num_sets: ignored silently.

Drain:
- The head entry is written lane 0 first through lane N-1, one per cycle, with no gaps while the buffer is non-empty.
- C_addr = base_addr + (written_sets*N + lane), modulo 2^ADDR_W. Addresses wrap silently.
- C_wr, C_addr and C_din are all registered.

Latency:
- A capture at edge t into an empty buffer gives lane 0 on C_wr at cycle t+1 and lane N-1 at t+N.

Full-buffer timing:
- A slot is freed on the same edge that its lane N-1 is written.
- A capture on that same edge is accepted, not counted as overflow.

Start priority:
- start in the same cycle as valid: start wins and the valid is ignored.
- start while ACTIVE: restart. Flush the buffer, abort the drain (no further writes from the old run), re-latch inputs, clear the flags.

Reset mid-drain: C_wr drops to 0 immediately (asynchronous); partial sets are lost.

Optional Feature:
Macro COLLECTOR_TAG_EN.
- Defined: adds output port C_set, width ADDR_W, registered alongside C_din. It carries the sequence index of the set being written (0..num_sets-1, counting dropped sets), so the verifier can detect which sets were lost to overflow.
- Undefined: port C_set and its logic are absent; all other behaviour is identical.

Test Plan:
1. start base=0x10 num_sets=1; one cycle later valid=6'h3F with C lanes 1..6 -> C_wr for 6 cycles, addr 0x10..0x15, data 1..6, first write 1 cycle after valid; done pulses once; overflow=0, lane_err=0.
2. num_sets=3, valid=6'h3F every 6 cycles -> 18 gap-free writes at addr base..base+17; done after the 18th; overflow=0.
3. num_sets=4, DEPTH_SETS=2, valid=6'h3F on 4 consecutive cycles -> 12 writes (sets 0,1); overflow=1 from the 3rd valid; done after the 12th write; with COLLECTOR_TAG_EN, C_set = 0 then 1.
4. ACTIVE, valid=6'h0F -> no writes, lane_err=1, busy stays 1; a later valid=6'h3F is captured normally.
5. base=0xFC num_sets=1, one full set -> addr FC,FD,FE,FF,00,01 in order.
6. rst asserted during lane 3 of a drain -> C_wr=0, busy=0, overflow=0 without waiting for a clock edge; after release, no writes until start.
